pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, cycles allowed in WAIT_LOCK before re-resetting the PLL.
REQ-004 SHALL have parameter LOSS_CNT_W, default 8, width of lock-loss counter.
REQ-005 SHALL have port refclk  input  1  free-running 50 MHz reference clock (same clock feeding the PLL); sole clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low block reset.
REQ-007 SHALL have port pll_locked  input  1  PLL locked indication, asynchronous to refclk.
REQ-008 SHALL have port relock_req  input  1  single-cycle request to force a PLL re-lock.
REQ-009 SHALL have port pll_rst  output  1  active-high reset driven to the PLL rst input.
REQ-010 SHALL have port sys_rst_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 SHALL have port ready  output  1  high only while in RUN.
REQ-012 SHALL have port timeout_err  output  1  sticky flag, lock timeout occurred.
REQ-013 SHALL have port lock_loss_cnt  output  LOSS_CNT_W  count of lock losses seen in RUN.
REQ-014 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-015 pll_locked SHALL pass through a two-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-016 FSM states SHALL be PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3.
REQ-017 PLL_RESET: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK with counter cleared.
REQ-018 WAIT_LOCK: counter increments each cycle; locked_s=1 -> STABLE; counter reaching LOCK_TIMEOUT_CYCLES-1 with locked_s=0 -> PLL_RESET and set timeout_err.
REQ-019 Timeout and locked_s=1 in the same cycle SHALL resolve to STABLE (lock wins), timeout_err unchanged.
REQ-020 STABLE: counts consecutive locked_s=1 cycles; locked_s=0 -> WAIT_LOCK with counter cleared; LOCK_STABLE_CYCLES-th consecutive cycle -> RUN.
REQ-021 RUN: sys_rst_n=1, ready=1; locked_s=0 -> WAIT_LOCK, sys_rst_n=0 and ready=0 from the next cycle, lock_loss_cnt += 1.
REQ-022 lock_loss_cnt SHALL saturate at all-ones, never wrap.
REQ-023 relock_req=1 in WAIT_LOCK, STABLE or RUN SHALL -> PLL_RESET next cycle; ignored in PLL_RESET (pulse not extended).
REQ-024 relock_req and lock loss together in RUN: relock priority (-> PLL_RESET), lock_loss_cnt still increments.
REQ-025 sys_rst_n SHALL be 0 and ready 0 in every state other than RUN; pll_rst SHALL be 1 only in PLL_RESET.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-027 timeout_err SHALL clear only on rst.
REQ-028 Counters SHALL be sized to clog2 of the largest count parameter; no overflow in any state.

Reset
REQ-029 rst=0 SHALL asynchronously force state=PLL_RESET, pll_rst=1, sys_rst_n=0, ready=0, timeout_err=0, lock_loss_cnt=0, counters and synchronizer=0.
REQ-030 On rst release, PLL_RESET SHALL run a full PLL_RST_CYCLES pulse counted from the first refclk edge with rst=1.
REQ-031 rst asserted mid-operation (any state) SHALL take effect without waiting for a refclk edge.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-032 Release rst, raise pll_locked at cycle 10 and hold -> pll_rst high cycles 0-3, ready rises 2+8 cycles after pll_locked (plus 1 register), sys_rst_n=1 together.
REQ-033 Hold pll_locked=0 -> pll_rst re-pulses 4 cycles after 32 WAIT_LOCK cycles, timeout_err=1 and stays 1 after later lock.
REQ-034 In RUN drop pll_locked for 1 cycle, 3 times -> sys_rst_n falls each time, lock_loss_cnt=3, ready returns after 8 stable cycles each time.
REQ-035 Glitch pll_locked low at STABLE count 5 -> returns to WAIT_LOCK, ready delayed by a full fresh 8 cycles.
REQ-036 Pulse relock_req in RUN simultaneously with lock loss -> state=PLL_RESET, pll_rst 4 cycles, lock_loss_cnt +1; LOSS_CNT_W=2 with 5 losses -> saturates at 3.
REQ-037 Assert rst mid-STABLE between clock edges -> all outputs take reset values immediately.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Brings a PLL out of reset, waits for a stable synchronized lock, then releases
// the downstream reset; re-sequences on lock loss, lock timeout or relock request.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  timeout_err,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state
);

    localparam int MAX_RS  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lock_meta;
    logic             locked_s;
    logic             started_q;
    logic             set_timeout;
    logic             loss_event;

    // Two-flop synchronizer; nothing downstream looks at pll_locked directly.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // The first edge after reset release is the start of the PLL reset pulse,
    // so the pulse counter only begins advancing on the edge after it.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q <= PLL_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        set_timeout = 1'b0;
        loss_event  = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (!started_q) begin
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle wins and is not an error.
                set_timeout = !locked_s && (cnt_q == TO_LAST);
                if (relock_req) begin
                    state_d = PLL_RESET;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = PLL_RESET;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (relock_req) begin
                    state_d = PLL_RESET;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d      = '0;
                // A loss is counted even when a relock request takes priority.
                loss_event = !locked_s;
                if (relock_req) begin
                    state_d = PLL_RESET;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            timeout_err   <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            pll_rst   <= (state_d == PLL_RESET);
            sys_rst_n <= (state_d == RUN);
            ready     <= (state_d == RUN);
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (loss_event && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with literal expectations,
// then randomized lock/relock traffic, all checked every cycle against a mode/elapsed model.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int LW  = 2;
    localparam int LOSS_MAX = (1 << LW) - 1;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STB  = 2;
    localparam int M_RUN  = 3;

    // clock / reset
    logic          refclk     = 1'b0;
    logic          rst        = 1'b0;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          timeout_err;
    logic [LW-1:0] lock_loss_cnt;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .LOSS_CNT_W         (LW)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .timeout_err  (timeout_err),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always @(posedge refclk or negedge rst) begin
        if (!rst) cyc <= -1;
        else      cyc <= cyc + 1;
    end

    // Reference model: current mode plus the number of cycles spent in it.
    int   m_mode = M_RST;
    int   m_n    = 0;
    logic m_p1   = 1'b0;
    logic m_p2   = 1'b0;
    logic m_terr = 1'b0;
    int   m_loss = 0;

    function automatic int next_mode(int md, int n, logic ls, logic rq);
        if (md == M_RST) return (n == PRC) ? M_WAIT : M_RST;
        if (rq) return M_RST;
        case (md)
            M_WAIT:  return ls ? M_STB : ((n == LTC) ? M_RST : M_WAIT);
            M_STB:   return !ls ? M_WAIT : ((n == LSC) ? M_RUN : M_STB);
            default: return ls ? M_RUN : M_WAIT;
        endcase
    endfunction

    always @(posedge refclk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_RST;
            m_n    <= 0;
            m_p1   <= 1'b0;
            m_p2   <= 1'b0;
            m_terr <= 1'b0;
            m_loss <= 0;
        end else begin
            m_mode <= next_mode(m_mode, m_n, m_p2, relock_req);
            m_n    <= (next_mode(m_mode, m_n, m_p2, relock_req) != m_mode) ? 1 : m_n + 1;
            m_p1   <= pll_locked;
            m_p2   <= m_p1;
            m_terr <= m_terr | ((m_mode == M_WAIT) && !m_p2 && (m_n == LTC));
            m_loss <= ((m_mode == M_RUN) && !m_p2 && (m_loss < LOSS_MAX)) ? m_loss + 1 : m_loss;
        end
    end

    // scoreboard
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    always @(negedge refclk) begin
        chk("state",         int'(state),         m_mode);
        chk("pll_rst",       int'(pll_rst),       int'(m_mode == M_RST));
        chk("sys_rst_n",     int'(sys_rst_n),     int'(m_mode == M_RUN));
        chk("ready",         int'(ready),         int'(m_mode == M_RUN));
        chk("timeout_err",   int'(timeout_err),   int'(m_terr));
        chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
    end

    // driver tasks
    task automatic goto(input int k);
        while (cyc < k) @(negedge refclk);
    endtask

    task automatic pulse_low(input int c);
        goto(c);
        pll_locked = 1'b0;
        goto(c + 1);
        pll_locked = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge refclk);
        chk("rst_pll_rst",   int'(pll_rst),   1);
        chk("rst_sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_state",     int'(state),     0);
        rst = 1'b1;

        // Power-up: pulse cycles 0-3, lock raised at 10, RUN at 21.
        goto(3);   chk("pu_pll_rst3", int'(pll_rst), 1);
        goto(4);   chk("pu_pll_rst4", int'(pll_rst), 0);
                   chk("pu_state4",   int'(state),   1);
        goto(10);  pll_locked = 1'b1;
        goto(20);  chk("pu_ready20", int'(ready), 0);
        goto(21);  chk("pu_ready21", int'(ready), 1);
                   chk("pu_srn21",   int'(sys_rst_n), 1);

        // Single-cycle lock losses in RUN.
        pulse_low(30);
        goto(32);  chk("loss1_ready32", int'(ready), 1);
        goto(33);  chk("loss1_ready33", int'(ready), 0);
                   chk("loss1_srn33",   int'(sys_rst_n), 0);
                   chk("loss1_cnt33",   int'(lock_loss_cnt), 1);
        goto(41);  chk("loss1_ready41", int'(ready), 0);
        goto(42);  chk("loss1_ready42", int'(ready), 1);
        pulse_low(50);

        // Relock request coinciding with a lock loss.
        goto(70);  pll_locked = 1'b0;
        goto(71);  pll_locked = 1'b1;
        goto(72);  relock_req = 1'b1;
        goto(73);  relock_req = 1'b0;
                   chk("rl_state73",   int'(state), 0);
                   chk("rl_pll_rst73", int'(pll_rst), 1);
                   chk("rl_cnt73",     int'(lock_loss_cnt), 3);
        goto(76);  chk("rl_pll_rst76", int'(pll_rst), 1);
        goto(77);  chk("rl_pll_rst77", int'(pll_rst), 0);
                   chk("rl_state77",   int'(state), 1);
        goto(90);  chk("rl_ready90",   int'(ready), 1);

        // Glitch after five stable counts restarts the stable window.
        pulse_low(100);
        goto(104); chk("gl_state104", int'(state), 2);
        pulse_low(107);
        goto(110); chk("gl_state110", int'(state), 1);
        goto(118); chk("gl_ready118", int'(ready), 0);
        goto(119); chk("gl_ready119", int'(ready), 1);
        pulse_low(130);
        goto(150); chk("sat_cnt150", int'(lock_loss_cnt), 3);

        // Lock timeout.
        goto(160); pll_locked = 1'b0;
        goto(194); chk("to_terr194",    int'(timeout_err), 0);
                   chk("to_pll_rst194", int'(pll_rst), 0);
        goto(195); chk("to_terr195",    int'(timeout_err), 1);
                   chk("to_pll_rst195", int'(pll_rst), 1);
        goto(198); chk("to_pll_rst198", int'(pll_rst), 1);
        goto(199); chk("to_state199",   int'(state), 1);
        goto(210); pll_locked = 1'b1;
        goto(240); chk("to_terr240",  int'(timeout_err), 1);
                   chk("to_ready240", int'(ready), 1);

        // Asynchronous reset in the middle of STABLE.
        pulse_low(250);
        goto(256); chk("ar_state256", int'(state), 2);
        #3 rst = 1'b0;
        #1;
        chk("ar_state",   int'(state), 0);
        chk("ar_pll_rst", int'(pll_rst), 1);
        chk("ar_srn",     int'(sys_rst_n), 0);
        chk("ar_ready",   int'(ready), 0);
        chk("ar_terr",    int'(timeout_err), 0);
        chk("ar_cnt",     int'(lock_loss_cnt), 0);
        repeat (2) @(negedge refclk);
        rst = 1'b1;

        // Randomized lock behaviour and relock requests.
        repeat (3000) begin
            @(negedge refclk);
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            relock_req = ($urandom_range(0, 149) == 0);
        end
        relock_req = 1'b0;
        @(negedge refclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
